// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module  : hazard_ctrl_if
// Brief   : Hazard-controller signal bundle (ID/EX/MEM status in, pipeline controls out).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_use_rs1;
  logic        ID_use_rs2;
  logic [4:0]  EX_rd;
  logic        EX_MemRead;
  logic        EX_redirect;
  logic        MEM_req;
  logic        MEM_ack;

  logic        PC_pause;
  logic        IF_ID_pause;
  logic        IF_ID_flush;
  logic        ID_EX_pause;
  logic        ID_EX_flush;
  logic        EX_MEM_pause;
  logic        MEM_WB_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
           EX_redirect, MEM_req, MEM_ack,
    input  PC_pause, IF_ID_pause, IF_ID_flush, ID_EX_pause, ID_EX_flush,
           EX_MEM_pause, MEM_WB_flush, mem_timeout, stall_cycles
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
           EX_redirect, MEM_req, MEM_ack,
    output PC_pause, IF_ID_pause, IF_ID_flush, ID_EX_pause, ID_EX_flush,
           EX_MEM_pause, MEM_WB_flush, mem_timeout, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : hazard_ctrl
// Brief   : Five-stage pipeline pause/flush controller: memory waits, redirects, load-use.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  wire logic    clk,
  input  wire logic    rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic w_lu;
  logic w_timeout;
  logic w_freeze;
  logic w_pc_pause;
  logic w_if_id_pause;
  logic w_if_id_flush;
  logic w_id_ex_pause;
  logic w_id_ex_flush;
  logic w_ex_mem_pause;
  logic w_mem_wb_flush;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_lu = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
                ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                 (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd)));

  assign w_timeout = (state_q == ST_WAIT) && !hz.MEM_ack && (wait_cnt_q == c_wait_last);

  assign w_freeze = ((state_q == ST_RUN)  && hz.MEM_req && !hz.MEM_ack) ||
                    ((state_q == ST_WAIT) && !hz.MEM_ack && !w_timeout);

  always_comb begin
    w_pc_pause     = 1'b0;
    w_if_id_pause  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_pause  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_pause = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (rst) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_freeze) begin
      // Redirect and load-use are held upstream until the memory stage releases.
      w_pc_pause     = 1'b1;
      w_if_id_pause  = 1'b1;
      w_id_ex_pause  = 1'b1;
      w_ex_mem_pause = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (hz.EX_redirect) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end else if (w_lu) begin
      w_pc_pause     = 1'b1;
      w_if_id_pause  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q | w_timeout;
    stall_cycles_d = stall_cycles_q + {31'd0, w_pc_pause};
    case (state_q)
      ST_RUN: begin
        if (hz.MEM_req && !hz.MEM_ack) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_WAIT: begin
        if (hz.MEM_ack || w_timeout) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.PC_pause     = w_pc_pause;
  assign hz.IF_ID_pause  = w_if_id_pause;
  assign hz.IF_ID_flush  = w_if_id_flush;
  assign hz.ID_EX_pause  = w_id_ex_pause;
  assign hz.ID_EX_flush  = w_id_ex_flush;
  assign hz.EX_MEM_pause = w_ex_mem_pause;
  assign hz.MEM_WB_flush = w_mem_wb_flush;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : tb_hazard_ctrl
// Brief   : Directed and random checks of hazard_ctrl against a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int total = 0;
  int bad   = 0;
  int seen_pause = 0;

  // Model: is an access outstanding, how many wait cycles have elapsed, sticky flag, stall count.
  bit          m_busy;
  int          m_waited;
  bit          m_to;
  logic [31:0] m_stall;

  task automatic m_reset();
    m_busy   = 1'b0;
    m_waited = 0;
    m_to     = 1'b0;
    m_stall  = 32'd0;
  endtask

  function automatic bit m_lu();
    if (!hz.EX_MemRead || hz.EX_rd == 5'd0) return 1'b0;
    return (hz.ID_use_rs1 && hz.ID_rs1 == hz.EX_rd) || (hz.ID_use_rs2 && hz.ID_rs2 == hz.EX_rd);
  endfunction

  function automatic bit m_tmo();
    return m_busy && !hz.MEM_ack && (m_waited == TMO - 1);
  endfunction

  function automatic bit m_frz();
    if (!m_busy) return hz.MEM_req && !hz.MEM_ack;
    return !hz.MEM_ack && !m_tmo();
  endfunction

  // Bit order: PC_p, IFID_p, IFID_f, IDEX_p, IDEX_f, EXMEM_p, MEMWB_f, mem_timeout
  function automatic logic [7:0] exp_ctrl();
    if (rst) return 8'b0010_1010;
    if (m_frz())              return {7'b1101_011, m_to};
    else if (hz.EX_redirect)  return {7'b0010_100, m_to};
    else if (m_lu())          return {7'b1100_100, m_to};
    return {7'b0000_000, m_to};
  endfunction

  function automatic logic [7:0] obs_ctrl();
    return {hz.PC_pause, hz.IF_ID_pause, hz.IF_ID_flush, hz.ID_EX_pause,
            hz.ID_EX_flush, hz.EX_MEM_pause, hz.MEM_WB_flush, hz.mem_timeout};
  endfunction

  task automatic m_step();
    bit tmo;
    bit frz;
    if (rst) begin
      m_reset();
    end else begin
      tmo = m_tmo();
      frz = m_frz();
      if (frz || (!hz.EX_redirect && m_lu())) m_stall = m_stall + 32'd1;
      if (tmo) m_to = 1'b1;
      if (!m_busy) begin
        if (hz.MEM_req && !hz.MEM_ack) begin
          m_busy   = 1'b1;
          m_waited = 0;
        end
      end else if (hz.MEM_ack || tmo) begin
        m_busy = 1'b0;
      end else begin
        m_waited = m_waited + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hz.ID_rs1 = 5'd0; hz.ID_rs2 = 5'd0; hz.ID_use_rs1 = 1'b0; hz.ID_use_rs2 = 1'b0;
    hz.EX_rd = 5'd0; hz.EX_MemRead = 1'b0; hz.EX_redirect = 1'b0;
    hz.MEM_req = 1'b0; hz.MEM_ack = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, "/ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl()));
    chk({tag, "/stall"}, hz.stall_cycles, m_stall);
    if (hz.PC_pause === 1'b1) seen_pause++;
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset();
    #2;
    chk("reset/ctrl", 32'(obs_ctrl()), 32'h2A);
    chk("reset/stall", hz.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use interlock: one bubble, then the load has moved on.
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd5; hz.ID_rs2 = 5'd5; hz.ID_use_rs2 = 1'b1;
    cycle("lu");
    hz.EX_MemRead = 1'b0;
    cycle("lu_after");
    chk("lu/stall_one", hz.stall_cycles, 32'd1);

    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd0; hz.ID_rs2 = 5'd0;
    cycle("lu_x0");
    chk("lu_x0/pc_pause", 32'(hz.PC_pause), 32'd0);

    // Redirect in the same cycle as a load-use hazard squashes the dependent op.
    hz.EX_rd = 5'd7; hz.ID_rs1 = 5'd7; hz.ID_use_rs1 = 1'b1; hz.EX_redirect = 1'b1;
    cycle("redir_lu");
    idle();
    cycle("redir_after");
    chk("redir/stall_same", hz.stall_cycles, 32'd1);

    // Memory ack three cycles after the request.
    seen_pause = 0;
    hz.MEM_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mem_wait");
    hz.MEM_ack = 1'b1;
    cycle("mem_ack");
    idle();
    cycle("mem_run");
    chk("mem/frozen_cycles", 32'(seen_pause), 32'd3);
    chk("mem/stall_total", hz.stall_cycles, 32'd4);

    hz.MEM_req = 1'b1; hz.MEM_ack = 1'b1;
    cycle("mem_same_cycle");
    idle();

    // Timeout: four frozen cycles, release, sticky flag afterwards.
    seen_pause = 0;
    hz.MEM_req = 1'b1;
    for (int i = 0; i < 5; i++) cycle("tmo");
    idle();
    cycle("tmo_after");
    chk("tmo/frozen_cycles", 32'(seen_pause), 32'd4);
    chk("tmo/flag", 32'(hz.mem_timeout), 32'd1);
    cycle("tmo_hold");

    // Reset mid-WAIT with two wait cycles elapsed.
    hz.MEM_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("pre_rst");
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_mid/ctrl", 32'(obs_ctrl()), 32'h2A);
    chk("rst_mid/stall", hz.stall_cycles, 32'd0);
    idle();
    cycle("rst_hold");
    rst = 1'b0;
    cycle("rst_run");
    chk("rst_mid/in_run", 32'(hz.PC_pause), 32'd0);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      hz.ID_rs1      = 5'($urandom_range(0, 3));
      hz.ID_rs2      = 5'($urandom_range(0, 3));
      hz.ID_use_rs1  = 1'($urandom_range(0, 1));
      hz.ID_use_rs2  = 1'($urandom_range(0, 1));
      hz.EX_rd       = 5'($urandom_range(0, 3));
      hz.EX_MemRead  = 1'($urandom_range(0, 1));
      hz.EX_redirect = ($urandom_range(0, 4) == 0);
      hz.MEM_req     = ($urandom_range(0, 2) == 0);
      hz.MEM_ack     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        m_reset();
      end else begin
        rst = 1'b0;
      end
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU. It produces the Pause and Flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It covers load-use interlocks, taken-branch/jump redirects, and multi-cycle memory/MMIO waits with a bounded timeout. It sits beside the datapath and is driven by decoded ID fields, EX load/redirect status, and the MEM-stage bus handshake.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles on one memory access before forced release; legal range 2..255.
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_rs1, ID_rs2  input  5 each  source register indices of the instruction in ID.
- ID_use_rs1, ID_use_rs2  input  1 each  the ID instruction actually reads rs1 / rs2.
- EX_rd  input  5  destination register of the instruction in EX.
- EX_MemRead  input  1  the EX instruction is a load.
- EX_redirect  input  1  EX resolved a taken branch or jump, so the PC is redirected.
- MEM_req  input  1  the MEM instruction is accessing data memory or MMIO.
- MEM_ack  input  1  data memory / MMIO completes the access this cycle.
- PC_pause  output  1  hold the PC.
- IF_ID_pause, IF_ID_flush  output  1 each  IF/ID register controls.
- ID_EX_pause, ID_EX_flush  output  1 each  ID/EX register controls.
- EX_MEM_pause  output  1  hold the EX/MEM register.
- MEM_WB_flush  output  1  insert a bubble into MEM/WB.
- mem_timeout  output  1  sticky flag: a memory access timed out.
- stall_cycles  output  32  count of cycles with PC_pause high; wraps modulo 2^32.

## Operation
- FSM states:
  - RUN: normal operation.
  - WAIT: memory access outstanding.
- Internal 8-bit wait_cnt is cleared on entry to WAIT and increments on every WAIT cycle.
- freeze is high in either of these cases:
  - state=RUN, MEM_req=1 and MEM_ack=0.
  - state=WAIT and MEM_ack=0 and the timeout condition is false.
- Timeout condition: state=WAIT, MEM_ack=0, and wait_cnt=MEM_TIMEOUT-1.
- Load-use condition (lu) requires all of the following:
  - EX_MemRead=1 and EX_rd≠0.
  - Either ID_use_rs1=1 with ID_rs1=EX_rd, or ID_use_rs2=1 with ID_rs2=EX_rd.
- Output priority, highest first. All outputs are combinational from state and inputs.
  1. freeze: PC_pause, IF_ID_pause, ID_EX_pause and EX_MEM_pause are all 1; MEM_WB_flush=1. All other flushes are 0. A redirect or lu during freeze is held, not acted on.
  2. EX_redirect: IF_ID_flush=1 and ID_EX_flush=1; all pauses are 0. This overrides lu, because the dependent instruction is squashed.
  3. lu: PC_pause=1 and IF_ID_pause=1; ID_EX_flush=1, giving a one-bubble interlock. All other outputs are 0.
  4. Otherwise all pause and flush outputs are 0.
- FSM transitions:
  - RUN→WAIT when MEM_req=1 and MEM_ack=0.
  - WAIT→RUN when MEM_ack=1 or on timeout.
  - On timeout, mem_timeout is set to 1 and held until rst.
- Pause and flush are never both 1 on the same register.
- While rst=1:
  - All pause outputs are 0.
  - IF_ID_flush, ID_EX_flush and MEM_WB_flush are 1.

## Timing
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- rst takes effect immediately, mid-WAIT included: FSM returns to RUN and the counters clear.
- The load-use interlock costs exactly 1 cycle. On the next edge the load has moved to MEM, so lu drops.
- Redirect flush lasts only for the cycle in which EX_redirect is high.
- Memory handshake:
  - MEM_ack in the same cycle as MEM_req causes no stall.
  - An ack after N wait cycles gives exactly N frozen cycles. The ack cycle itself is not frozen.
- Timeout releases the freeze in the cycle where wait_cnt=MEM_TIMEOUT-1. mem_timeout becomes visible after the following edge.
- stall_cycles increments on each edge where PC_pause was 1. It wraps from 0xFFFFFFFF to 0.

## Test plan
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs2=5, ID_use_rs2=1.
  - Response: PC_pause, IF_ID_pause and ID_EX_flush are 1 for exactly one cycle; stall_cycles goes 0→1.
  - Repeat with EX_rd=0: no stall.
- Redirect with lu in the same cycle.
  - Response: IF_ID_flush=ID_EX_flush=1, all pauses are 0, and stall_cycles is unchanged.
- MEM_req=1 with MEM_ack arriving 3 cycles later.
  - Response: 3 frozen cycles, MEM_WB_flush=1 during those cycles, FSM back in RUN after the ack edge, stall_cycles=3.
- MEM_TIMEOUT=4 and MEM_ack never asserted.
  - Response: freeze for 4 cycles (1 in RUN plus 3 in WAIT), release, then mem_timeout=1, held until rst.
- rst pulsed while in WAIT with wait_cnt=2.
  - Response: outputs immediately take their reset values, and the FSM is in RUN when rst drops.
